// File: rtl/arb_rr_4.sv
// arb_rr_4 : four-requester round-robin arbiter with registered one-hot grant.
//
// A requester wins from IDLE by a rotating-priority scan that starts at the
// pointer. It keeps the grant until it drops its request line. The pointer then
// moves to the slot after the released owner. At least one IDLE cycle always
// separates two grants.
//
// Optional feature (macro ARB_TIMEOUT_EN): a grant is revoked after TIMEOUT
// cycles of ownership, and `timeout` pulses for one cycle when that happens.
// Without the macro, `timeout` is constant 0 and a grant is held indefinitely.
//
// Parameters:
//   TIMEOUT   maximum grant hold in cycles (1..255), used only with ARB_TIMEOUT_EN
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        arbitration enable; gates new grants only
//   req[3:0]  level-sensitive request lines, bit i = client i
//   gnt[3:0]  one-hot grant, zero when no owner
//   gnt_id    index of the current or last owner
//   gnt_valid high while a grant is active
//   timeout   one-cycle pulse when a grant is revoked by timeout
module arb_rr_4 #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       timeout_q, timeout_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] winner_s;
   logic       expire_s;

   // First set request bit scanning ptr, ptr+1, ... with 2-bit wraparound.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found = found;
         end
      end
   endfunction

   assign winner_s = rr_pick(req, ptr_q);

`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   // Hold counter: zero in IDLE, so it is cleared on entry to BUSY.
   always_comb begin
      cnt_d = 8'd0;
      if (state_q == ST_BUSY) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = 8'd0;
      end
   end

   // cnt_q counts BUSY cycles already elapsed. When it reaches TIMEOUT-1, the
   // grant has been visible for TIMEOUT cycles and the coming edge revokes it.
   assign expire_s = (state_q == ST_BUSY) && (cnt_q == 8'(TIMEOUT - 32'd1));

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   wire unused_timeout_s = ^8'(TIMEOUT);
   assign expire_s = 1'b0;
`endif

   // Next-state and next-output logic of the IDLE/BUSY controller.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && (req != 4'b0000)) begin
               gnt_id_d    = winner_s;
               gnt_valid_d = 1'b1;
               state_d     = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A release takes precedence over a timeout at the same edge.
            if (!req[gnt_id_q]) begin
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_id_q + 2'd1;
               state_d     = ST_IDLE;
            end else if (expire_s) begin
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_id_q + 2'd1;
               timeout_d   = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: begin
            gnt_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      if (gnt_valid_d) begin
         gnt_d = 4'b0001 << gnt_id_d;
      end else begin
         gnt_d = 4'b0000;
      end
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 2'd0;
         gnt_id_q    <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         gnt_q       <= 4'b0000;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         gnt_q       <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Testbench for arb_rr_4: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_arb_rr_4;

   localparam int TB_TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   arb_rr_4 #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_owner = -1;   // -1 = nobody owns the resource
   int m_ptr   = 0;
   int m_id    = 0;
   int m_held  = 0;    // cycles the current grant has been visible
   bit m_to    = 1'b0;
   bit m_live  = 1'b0;

   always @(posedge clk) begin
      int  win;
      bit  found;
      m_live = 1'b1;
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_id = 0; m_held = 0; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            if (en && req != 4'b0000) begin
               win = 0; found = 1'b0;
               for (int k = 0; k < 4; k++) begin
                  if (!found && req[(m_ptr + k) % 4]) begin
                     win = (m_ptr + k) % 4;
                     found = 1'b1;
                  end
               end
               m_owner = win; m_id = win; m_held = 1;
            end
         end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            m_owner = -1;
         end else if (TO_ON && m_held >= TB_TIMEOUT) begin
            m_ptr = (m_owner + 1) % 4;
            m_owner = -1;
            m_to = 1'b1;
         end else begin
            m_held = m_held + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [3:0] e_gnt;
      if (m_live) begin
         e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         chk("model_gnt", gnt, e_gnt);
         chk("model_gnt_id", {2'b00, gnt_id}, 4'(m_id));
         chk("model_gnt_valid", {3'b000, gnt_valid}, {3'b000, (m_owner >= 0)});
         chk("model_timeout", {3'b000, timeout}, {3'b000, m_to});
      end
   end

   // Apply inputs (called at a negedge) and return at the next negedge.
   task automatic tick(input logic [3:0] r, input logic e);
      req = r;
      en  = e;
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] r;
      rst = 1'b1; en = 1'b1; req = 4'b1111;
      @(negedge clk);
      chk("reset_gnt_0", gnt, 4'b0000);
      chk("reset_valid_0", {3'b000, gnt_valid}, 4'b0000);
      tick(4'b1111, 1'b1);
      chk("reset_gnt_1", gnt, 4'b0000);
      chk("reset_id_1", {2'b00, gnt_id}, 4'b0000);
      rst = 1'b0;
      tick(4'b1111, 1'b1);
      chk("first_grant", gnt, 4'b0001);

      // Round robin: each owner drops its request for one cycle.
      tick(4'b1110, 1'b1); chk("rr_idle0", gnt, 4'b0000);
      tick(4'b1111, 1'b1); chk("rr_g1", gnt, 4'b0010);
      tick(4'b1101, 1'b1); chk("rr_idle1", gnt, 4'b0000);
      tick(4'b1111, 1'b1); chk("rr_g2", gnt, 4'b0100);
      tick(4'b1011, 1'b1); chk("rr_idle2", gnt, 4'b0000);
      tick(4'b1111, 1'b1); chk("rr_g3", gnt, 4'b1000);
      tick(4'b0111, 1'b1); chk("rr_idle3", gnt, 4'b0000);
      tick(4'b1111, 1'b1); chk("rr_g0", gnt, 4'b0001);
      tick(4'b1110, 1'b1); chk("rr_rel0", gnt, 4'b0000);

      // Hold and ignore: client 2 keeps the grant while all request.
      tick(4'b1100, 1'b1); chk("hold_grant", gnt, 4'b0100);
`ifndef ARB_TIMEOUT_EN
      for (int i = 0; i < 10; i++) begin
         tick(4'b1111, 1'b1); chk("hold_stable", gnt, 4'b0100);
      end
`endif
      tick(4'b1011, 1'b1); chk("hold_rel", gnt, 4'b0000);
      tick(4'b1111, 1'b1); chk("hold_next", gnt, 4'b1000);
      tick(4'b0111, 1'b1); chk("hold_rel3", gnt, 4'b0000);

      // Enable gating.
      tick(4'b0101, 1'b0); chk("en_off_a", gnt, 4'b0000);
      tick(4'b0101, 1'b0); chk("en_off_b", gnt, 4'b0000);
      tick(4'b0101, 1'b1); chk("en_on", gnt, 4'b0001);
      tick(4'b0101, 1'b0); chk("en_drop_hold", gnt, 4'b0001);
      tick(4'b0100, 1'b0); chk("en_rel", gnt, 4'b0000);

      // Sparse requests and pointer wrap (ptr is now 1).
      tick(4'b0001, 1'b1); chk("scan_wrap", gnt, 4'b0001);
      tick(4'b0000, 1'b1); chk("scan_rel", gnt, 4'b0000);
      tick(4'b1000, 1'b1); chk("own3", gnt, 4'b1000);
      chk("own3_id", {2'b00, gnt_id}, 4'b0011);
      tick(4'b0001, 1'b1); chk("own3_rel", gnt, 4'b0000);
      chk("own3_id_kept", {2'b00, gnt_id}, 4'b0011);
      tick(4'b0001, 1'b1); chk("ptr_wrap0", gnt, 4'b0001);
      tick(4'b0000, 1'b1); chk("wrap_rel", gnt, 4'b0000);

`ifdef ARB_TIMEOUT_EN
      // Timeout: client 1 holds with req=0011 (ptr is 1).
      tick(4'b0011, 1'b1); chk("to_grant", gnt, 4'b0010);
      for (int i = 1; i < TB_TIMEOUT; i++) begin
         tick(4'b0011, 1'b1); chk("to_hold", gnt, 4'b0010);
      end
      tick(4'b0011, 1'b1);
      chk("to_revoke", gnt, 4'b0000);
      chk("to_pulse", {3'b000, timeout}, 4'b0001);
      tick(4'b0011, 1'b1);
      chk("to_next", gnt, 4'b0001);
      chk("to_pulse_end", {3'b000, timeout}, 4'b0000);
      tick(4'b0000, 1'b1);
`endif

      // Randomized phase: sticky request levels, occasional enable drop and reset.
      r = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         rst = ($urandom_range(0, 99) == 0);
         tick(r, ($urandom_range(0, 7) != 0));
      end
      rst = 1'b0;
      tick(4'b0000, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
